// File: rtl/arb2_pkg.sv
// arb2_pkg: shared state encoding and hold-counter width for the two-way arbiter.
package arb2_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;
    localparam int HOLD_W = 8;
endpackage

// File: rtl/arb2_hold_cnt.sv
// arb2_hold_cnt: saturating hold counter; clear, load-1, or count up to MAX_HOLD.
module arb2_hold_cnt import arb2_pkg::*; #(
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              ld_i,
    input  logic              inc_i,
    output logic [HOLD_W-1:0] cnt_o
);
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    always_comb
        cnt_d = clr_i ? '0 :
                ld_i  ? HOLD_W'(1) :
                (inc_i && cnt_q < HOLD_W'(MAX_HOLD)) ? cnt_q + HOLD_W'(1) : cnt_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    assign cnt_o = cnt_q;
endmodule

// File: rtl/arb2_ctrl.sv
// arb2_ctrl: two-requester arbiter with hold limit and forced hand-over.
// Define ARB2_RR_EN for round-robin tie-breaking; otherwise req[1] wins ties.
module arb2_ctrl import arb2_pkg::*; #(
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    output logic [1:0]        gnt,
    output logic              gnt_id,
    output logic              gnt_valid,
    output logic [HOLD_W-1:0] hold_cnt
);
    state_t state_q, state_d;
    logic   x, at_max, tie_win;
    logic   cnt_clr, cnt_ld, cnt_inc;
    assign x      = (state_q == GNT1);
    assign at_max = (hold_cnt >= HOLD_W'(MAX_HOLD));
`ifdef ARB2_RR_EN
    logic ptr_q;
    assign tie_win = ~ptr_q;
    always_ff @(posedge clk or posedge rst)
        if (rst)         ptr_q <= 1'b0;
        else if (cnt_ld) ptr_q <= (state_d == GNT1);
`else
    assign tie_win = 1'b1;
`endif
    // Unknown encodings fall through to IDLE.
    always_comb begin
        state_d = IDLE;
        if (state_q == IDLE)
            state_d = (req == 2'b11) ? (tie_win ? GNT1 : GNT0) :
                      req[1] ? GNT1 : req[0] ? GNT0 : IDLE;
        else if (state_q == GNT0 || state_q == GNT1)
            state_d = (req[!x] && (!req[x] || at_max)) ? (x ? GNT0 : GNT1) :
                      req[x] ? state_q : IDLE;
    end
    // Counter action follows purely from the state transition.
    assign cnt_clr = (state_d == IDLE);
    assign cnt_ld  = (state_d != IDLE) && (state_d != state_q);
    assign cnt_inc = (state_d != IDLE) && (state_d == state_q);
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q   <= IDLE;
            gnt       <= 2'b00;
            gnt_id    <= 1'b0;
            gnt_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt       <= {state_d == GNT1, state_d == GNT0};
            gnt_id    <= (state_d == GNT1);
            gnt_valid <= (state_d != IDLE);
        end
    arb2_hold_cnt #(.MAX_HOLD(MAX_HOLD)) u_hold (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr),
        .ld_i  (cnt_ld),
        .inc_i (cnt_inc),
        .cnt_o (hold_cnt)
    );
endmodule

// File: doc/arb2_ctrl.md
ARB2_CTRL -- requirements
Module: arb2_ctrl

Interface
REQ-001 Parameter MAX_HOLD, default 4, SHALL set the max consecutive grant cycles before forced hand-over when the other requester waits; legal range 1..255.
REQ-002 Port clk, input, 1, SHALL be the sole clock; all state updates on rising edge.
REQ-003 Port rst, input, 1, SHALL be an asynchronous, active-high reset.
REQ-004 Port req, input, 2, SHALL carry request lines, req[1] and req[0], one per requester.
REQ-005 Port gnt, output, 2, SHALL be a registered one-hot-or-zero grant vector.
REQ-006 Port gnt_id, output, 1, SHALL be the registered index of the granted requester; 0 when idle.
REQ-007 Port gnt_valid, output, 1, SHALL equal the OR of gnt bits, registered.
REQ-008 Port hold_cnt, output, 8, SHALL be the registered count of cycles the current holder has held the grant.

Function
REQ-009 FSM states IDLE, GNT0, GNT1 SHALL be the only states; any other encoding SHALL return to IDLE next cycle.
REQ-010 Latency: req asserted in cycle N from IDLE SHALL yield gnt in cycle N+1; no combinational path req->gnt.
REQ-011 IDLE, both req high: winner SHALL be chosen by the arbitration rule (REQ-018/019); one req high: that requester wins.
REQ-012 GNTx, req[x] still high, hold_cnt < MAX_HOLD: stay in GNTx, hold_cnt increments by 1.
REQ-013 GNTx, req[x] still high, hold_cnt == MAX_HOLD, other req high: move to other grant, hold_cnt = 1 (forced hand-over).
REQ-014 GNTx, req[x] still high, hold_cnt == MAX_HOLD, other req low: stay in GNTx, hold_cnt saturates at MAX_HOLD.
REQ-015 GNTx, req[x] dropped, other req high: switch directly to other grant next cycle, no idle bubble, hold_cnt = 1.
REQ-016 GNTx, req[x] dropped, other req low: go to IDLE, gnt = 0, gnt_id = 0, hold_cnt = 0.
REQ-017 gnt SHALL never have both bits set in any cycle.

Reset
REQ-020 On rst high, state = IDLE, gnt = 2'b00, gnt_id = 0, gnt_valid = 0, hold_cnt = 0, last-served pointer = 0, immediately and asynchronously.
REQ-021 Reset asserted mid-grant SHALL drop gnt in the same cycle; after release, arbitration SHALL restart from IDLE with no memory of prior holder.

Configuration
REQ-018 Macro ARB2_RR_EN defined: simultaneous contention SHALL grant the requester not equal to last-served pointer; pointer updates to winner on every grant entry; pointer 0 at reset, so req[1] wins first tie.
REQ-019 Macro ARB2_RR_EN undefined: simultaneous contention SHALL always grant req[1] (fixed priority, req[1] highest); no pointer register; hand-over rules REQ-013..016 unchanged.

Structure
REQ-022 Package arb2_pkg SHALL hold the state typedef (IDLE=2'b00, GNT0=2'b01, GNT1=2'b10) and the hold-counter width constant (8).
REQ-023 Sub-module arb2_hold_cnt SHALL implement the saturating hold counter (clear, load-1, increment, saturate at MAX_HOLD); FSM and arbitration stay in arb2_ctrl.

Verification
REQ-024 Reset: rst=1 with req=2'b11 for 3 cycles -> gnt=00, gnt_valid=0, hold_cnt=0 throughout.
REQ-025 Single request: req=2'b01 at cycle 0 -> gnt=01, gnt_id=0 at cycle 1; req drops at cycle 3 -> gnt=00 at cycle 4.
REQ-026 Tie from IDLE: req=2'b11 after reset -> gnt=10; ARB2_RR_EN build, release then re-tie -> gnt=01; without macro -> gnt=10.
REQ-027 Forced hand-over, MAX_HOLD=4: req=2'b11 held -> gnt alternates every 4 cycles, hold_cnt sequence 1,2,3,4,1,...
REQ-028 Saturation: MAX_HOLD=4, req=2'b01 held 10 cycles -> gnt=01 constant, hold_cnt stops at 4.
REQ-029 Reset mid-grant: gnt=10, hold_cnt=2, rst pulse -> gnt=00 same cycle; after release with req=2'b01 -> gnt=01 one cycle later.
